// File: rtl/deser_pingpong_pkg.sv
// deser_pingpong_pkg: the shared datapath package for the MIMO-OFDM chain.
//   complex_product_t : signed complex sample, DATA_W bits per component
//   DESER_BANKS       : number of ping-pong banks in the deserializer
//   bitrev()          : reverses the low 'width' bits of a value
package deser_pingpong_pkg;

    localparam int DATA_W      = 16;
    localparam int DESER_BANKS = 2;

    typedef struct packed {
        logic signed [DATA_W-1:0] re;
        logic signed [DATA_W-1:0] im;
    } complex_product_t;

    // Reverse the low 'width' bits of v; the upper bits of the result are zero.
    function automatic logic [31:0] bitrev(input logic [31:0] v, input int width);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < width) begin
                r = (r << 1) | ((v >> i) & 32'd1);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/deser_bank.sv
// deser_bank: one N-entry sample bank of the ping-pong deserializer.
//   clk, reset : clock, synchronous active-high reset (clears the bank)
//   we         : write P lanes this cycle
//   base       : frame position of lane 0 (beat index * P)
//   din        : P lanes, lane 0 earliest in time
//   dout       : full bank contents
// Build option DESER_BITREV_EN: when defined, frame position t is stored at
// index bitrev(t) instead of N-1-t, giving bit-reversed order for a DIT FFT.
module deser_bank
    import deser_pingpong_pkg::*;
#(
    parameter int N = 8,
    parameter int P = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         we,
    input  logic [$clog2(N)-1:0]         base,
    input  complex_product_t [P-1:0]     din,
    output complex_product_t [N-1:0]     dout
);

    localparam int LOG2N = $clog2(N);

    complex_product_t [N-1:0] mem;

    // Storage index for lane 'lane' of a beat whose first sample is at 'b'.
    function automatic logic [LOG2N-1:0] lane_index(input logic [LOG2N-1:0] b, input int lane);
        logic [LOG2N-1:0] pos;
        pos = b + LOG2N'(lane);
`ifdef DESER_BITREV_EN
        return LOG2N'(bitrev(32'(pos), LOG2N));
`else
        return LOG2N'(N - 1) - pos;
`endif
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            mem <= '0;
        end else if (we) begin
            for (int j = 0; j < P; j++) begin
                mem[lane_index(base, j)] <= din[j];
            end
        end
    end

    assign dout = mem;

endmodule

// File: rtl/deser_pingpong.sv
// deser_pingpong: ping-pong serial-to-parallel converter in front of the FFT.
// Collects N/P beats of P samples into an N-sample frame; one bank is shown
// to the consumer while the other fills.
//   clk, reset : clock, synchronous active-high reset
//   flush      : drop the partially filled frame (full banks untouched)
//   in_valid / in_ready / x_in    : input beat handshake, lane 0 earliest
//   out_valid / out_ready / x_out : frame handshake
//   frame_id   : bank currently presented, toggles per delivered frame
// Build option DESER_BITREV_EN selects bit-reversed storage (see deser_bank).
module deser_pingpong
    import deser_pingpong_pkg::*;
#(
    parameter int N = 8,
    parameter int P = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  complex_product_t [P-1:0] x_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output complex_product_t [N-1:0] x_out,
    output logic                     frame_id
);

    localparam int BEATS = N / P;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int LOG2N = $clog2(N);
    localparam int LOG2P = $clog2(P);

    logic [CW-1:0]          cnt;
    logic [DESER_BANKS-1:0] full;
    logic [DESER_BANKS-1:0] full_next;
    logic                   wr_bank;
    logic                   rd_bank;
    logic                   accept;
    logic                   last_beat;
    logic                   consume;
    logic [LOG2N-1:0]       base;

    complex_product_t [N-1:0] bank_q [DESER_BANKS];

    assign in_ready  = ~full[wr_bank];
    assign out_valid = full[rd_bank];
    assign x_out     = bank_q[rd_bank];
    assign frame_id  = rd_bank;

    // Flush outranks the beat presented alongside it.
    assign accept    = in_valid & in_ready & ~flush;
    assign last_beat = (cnt == CW'(BEATS - 1));
    assign consume   = out_valid & out_ready;
    assign base      = LOG2N'(cnt) << LOG2P;

    // Completion only ever targets an empty bank and consume a full one, so
    // the two updates never collide.
    always_comb begin
        full_next = full;
        if (accept && last_beat) begin
            full_next[wr_bank] = 1'b1;
        end
        if (consume) begin
            full_next[rd_bank] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            full    <= '0;
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
        end else begin
            full <= full_next;
            if (flush) begin
                cnt <= '0;
            end else if (accept) begin
                if (last_beat) begin
                    cnt     <= '0;
                    wr_bank <= ~wr_bank;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
            if (consume) begin
                rd_bank <= ~rd_bank;
            end
        end
    end

    for (genvar b = 0; b < DESER_BANKS; b++) begin : g_bank
        deser_bank #(
            .N (N),
            .P (P)
        ) u_bank (
            .clk   (clk),
            .reset (reset),
            .we    (accept && (wr_bank == 1'(b))),
            .base  (base),
            .din   (x_in),
            .dout  (bank_q[b])
        );
    end

endmodule

// File: tb/tb_deser_pingpong.sv
// tb_deser_pingpong: self-checking bench for deser_pingpong (N=8, P=2).
// A reference model keeps the stream of accepted samples and a queue of
// completed frames; expected outputs are derived from that queue.
module tb_deser_pingpong;
    import deser_pingpong_pkg::*;

    localparam int N = 8;
    localparam int P = 2;

    typedef complex_product_t [N-1:0] frame_t;
    typedef complex_product_t [P-1:0] beat_t;

    logic   clk = 1'b0;
    logic   reset;
    logic   flush;
    logic   in_valid;
    logic   in_ready;
    beat_t  x_in;
    logic   out_valid;
    logic   out_ready;
    frame_t x_out;
    logic   frame_id;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    complex_product_t partial[$];
    frame_t           frames[$];
    int               delivered = 0;

    deser_pingpong #(.N(N), .P(P)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_in      (x_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .x_out     (x_out),
        .frame_id  (frame_id)
    );

    always #5 clk = ~clk;

    // Where the t-th sample of a frame ends up in x_out.
    function automatic int map_index(input int t);
`ifdef DESER_BITREV_EN
        int r;
        r = 0;
        for (int i = 0; i < $clog2(N); i++) r = r * 2 + ((t >> i) & 1);
        return r;
`else
        return N - 1 - t;
`endif
    endfunction

    function automatic frame_t build_frame();
        frame_t f;
        f = '0;
        for (int t = 0; t < N; t++) f[map_index(t)] = partial[t];
        return f;
    endfunction

    function automatic complex_product_t mk(input int v);
        complex_product_t c;
        c.re = DATA_W'(v);
        c.im = '0;
        return c;
    endfunction

    function automatic beat_t beat2(input int a, input int b);
        beat_t x;
        x[0] = mk(a);
        x[1] = mk(b);
        return x;
    endfunction

    function automatic beat_t rnd_beat();
        beat_t x;
        for (int j = 0; j < P; j++) x[j] = complex_product_t'($urandom);
        return x;
    endfunction

    // One clock: drive inputs, advance the model on the edge, return at negedge.
    task automatic step(input logic rst_i, input logic fl, input logic iv,
                        input beat_t x, input logic ordy);
        bit cons;
        bit rdy;
        reset     = rst_i;
        flush     = fl;
        in_valid  = iv;
        x_in      = x;
        out_ready = ordy;
        @(posedge clk);
        if (rst_i) begin
            partial.delete();
            frames.delete();
            delivered = 0;
        end else begin
            cons = (frames.size() > 0) && ordy;
            rdy  = (frames.size() < 2);
            if (fl) begin
                partial.delete();
            end else if (iv && rdy) begin
                for (int j = 0; j < P; j++) partial.push_back(x[j]);
                if (partial.size() == N) begin
                    frames.push_back(build_frame());
                    partial.delete();
                end
            end
            if (cons) begin
                void'(frames.pop_front());
                delivered++;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        step(1, 0, 0, '0, 0);
        step(1, 0, 0, '0, 0);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_checks++; if (frame_id !== 1'b0) begin n_fail++; $display("FAIL reset_frame_id: got %b want 0", frame_id); end
        n_checks++; if (x_out !== frame_t'('0)) begin n_fail++; $display("FAIL reset_x_out: got %h want 0", x_out); end
        step(0, 0, 0, '0, 0);
    endtask

    task automatic test_basic_fill();
        frame_t exp;
        for (int k = 0; k < 4; k++) begin
            step(0, 0, 1, beat2(2 * k + 1, 2 * k + 2), 0);
            if (k == 2) begin
                n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL fill_early_valid: got %b want 0", out_valid); end
            end
        end
        step(0, 0, 0, '0, 0);
        exp = '0;
        for (int t = 0; t < N; t++) exp[map_index(t)] = mk(t + 1);
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL fill_out_valid: got %b want 1", out_valid); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL fill_in_ready: got %b want 1", in_ready); end
        n_checks++; if (x_out !== exp) begin n_fail++; $display("FAIL fill_x_out: got %h want %h", x_out, exp); end
        n_checks++; if (frame_id !== 1'b0) begin n_fail++; $display("FAIL fill_frame_id: got %b want 0", frame_id); end
    endtask

    task automatic test_backpressure();
        frame_t f0;
        f0 = frames[0];
        for (int k = 0; k < 8; k++) begin
            n_checks++;
            if (in_ready !== (frames.size() < 2)) begin
                n_fail++; $display("FAIL bp_in_ready beat %0d: got %b want %b", k, in_ready, frames.size() < 2);
            end
            step(0, 0, 1, beat2(100 + 2 * k, 101 + 2 * k), 0);
        end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full_in_ready: got %b want 0", in_ready); end
        n_checks++; if (x_out !== f0) begin n_fail++; $display("FAIL bp_hold_x_out: got %h want %h", x_out, f0); end
        step(0, 0, 0, '0, 1);
        n_checks++; if (frame_id !== 1'b1) begin n_fail++; $display("FAIL bp_frame_id: got %b want 1", frame_id); end
        n_checks++; if (x_out !== frames[0]) begin n_fail++; $display("FAIL bp_frame1: got %h want %h", x_out, frames[0]); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_after_consume: got %b want 1", in_ready); end
        step(0, 0, 0, '0, 1);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drained: got %b want 0", out_valid); end
    endtask

    task automatic test_streaming();
        int got;
        got = 0;
        step(1, 0, 0, '0, 0);
        for (int c = 0; c <= 64; c++) begin
            if (c < 64) begin
                n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_stall cycle %0d: got %b want 1", c, in_ready); end
            end
            n_checks++; if (out_valid !== (frames.size() > 0)) begin n_fail++; $display("FAIL stream_valid cycle %0d: got %b want %b", c, out_valid, frames.size() > 0); end
            if (frames.size() > 0) begin
                n_checks++; if (x_out !== frames[0]) begin n_fail++; $display("FAIL stream_x_out cycle %0d: got %h want %h", c, x_out, frames[0]); end
                n_checks++; if (frame_id !== 1'(delivered)) begin n_fail++; $display("FAIL stream_frame_id cycle %0d: got %b want %b", c, frame_id, 1'(delivered)); end
            end
            if (out_valid === 1'b1) got++;
            step(0, 0, c < 64, rnd_beat(), 1);
        end
        n_checks++; if (got != 16) begin n_fail++; $display("FAIL stream_frames: got %0d want 16", got); end
    endtask

    task automatic test_flush();
        frame_t exp;
        step(1, 0, 0, '0, 0);
        step(0, 0, 1, rnd_beat(), 0);
        step(0, 0, 1, rnd_beat(), 0);
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_in_ready: got %b want 1", in_ready); end
        step(0, 1, 1, rnd_beat(), 0);
        for (int k = 0; k < 4; k++) begin
            n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_early_valid beat %0d: got %b want 0", k, out_valid); end
            step(0, 0, 1, beat2(9 + 2 * k, 10 + 2 * k), 0);
        end
        exp = '0;
        for (int t = 0; t < N; t++) exp[map_index(t)] = mk(9 + t);
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL flush_out_valid: got %b want 1", out_valid); end
        n_checks++; if (x_out !== exp) begin n_fail++; $display("FAIL flush_x_out: got %h want %h", x_out, exp); end
        step(0, 0, 0, '0, 1);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_single_frame: got %b want 0", out_valid); end
    endtask

    task automatic test_reset_mid();
        step(1, 0, 0, '0, 0);
        for (int k = 0; k < 7; k++) step(0, 0, 1, rnd_beat(), 0);
        step(1, 0, 1, rnd_beat(), 1);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_out_valid: got %b want 0", out_valid); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_in_ready: got %b want 1", in_ready); end
        n_checks++; if (x_out !== frame_t'('0)) begin n_fail++; $display("FAIL rst_mid_x_out: got %h want 0", x_out); end
        for (int k = 0; k < 4; k++) step(0, 0, 1, rnd_beat(), 0);
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rst_mid_refill_valid: got %b want 1", out_valid); end
        n_checks++; if (x_out !== frames[0]) begin n_fail++; $display("FAIL rst_mid_refill_x_out: got %h want %h", x_out, frames[0]); end
        n_checks++; if (frame_id !== 1'b0) begin n_fail++; $display("FAIL rst_mid_frame_id: got %b want 0", frame_id); end
    endtask

    task automatic test_random();
        logic iv, ordy, fl;
        step(1, 0, 0, '0, 0);
        for (int c = 0; c < 400; c++) begin
            n_checks++; if (in_ready !== (frames.size() < 2)) begin n_fail++; $display("FAIL rand_in_ready cycle %0d: got %b want %b", c, in_ready, frames.size() < 2); end
            n_checks++; if (out_valid !== (frames.size() > 0)) begin n_fail++; $display("FAIL rand_out_valid cycle %0d: got %b want %b", c, out_valid, frames.size() > 0); end
            if (frames.size() > 0) begin
                n_checks++; if (x_out !== frames[0]) begin n_fail++; $display("FAIL rand_x_out cycle %0d: got %h want %h", c, x_out, frames[0]); end
                n_checks++; if (frame_id !== 1'(delivered)) begin n_fail++; $display("FAIL rand_frame_id cycle %0d: got %b want %b", c, frame_id, 1'(delivered)); end
            end
            iv   = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 2) == 0);
            fl   = ($urandom_range(0, 19) == 0);
            step(0, fl, iv, rnd_beat(), ordy);
        end
    endtask

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        x_in      = '0;
        out_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic_fill();
        test_backpressure();
        test_streaming();
        test_flush();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
